// File: rtl/cand_sweep_pkg.sv
// Shared constants for the candidate sweep generator: FSM state encodings,
// default widths and Galois LFSR tap masks.
package cand_sweep_pkg;

    localparam int W_DEF          = 21;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Right-shifting Galois masks; widths not listed fall back to a single tap,
    // which is not maximal length.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            8:       lfsr_taps = 64'h0000_00B8;
            16:      lfsr_taps = 64'h0000_B400;
            20:      lfsr_taps = 64'h0009_0000;
            21:      lfsr_taps = 64'h0014_0000;
            24:      lfsr_taps = 64'h00E1_0000;
            31:      lfsr_taps = 64'h4800_0000;
            32:      lfsr_taps = 64'h8020_0003;
            default: lfsr_taps = 64'd1 << (w - 1);
        endcase
    endfunction

endpackage

// File: rtl/cand_sweep_if.sv
// Control, checker and hit-stream signals of the candidate sweep generator.
// The slave modport is the generator side; the master modport is its environment.
interface cand_sweep_if
    import cand_sweep_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             mode_lfsr;
    logic [W-1:0]     seed;
    logic [CNT_W-1:0] max_evals;
    logic [CNT_W-1:0] max_hits;
    logic             abort;
    logic [W-1:0]     cand;
    logic             sat;
    logic [W-1:0]     hit_data;
    logic             hit_valid;
    logic             hit_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] hit_cnt;

    modport slave (
        input  start, mode_lfsr, seed, max_evals, max_hits, abort, sat, hit_ready,
        output cand, hit_data, hit_valid, busy, done, eval_cnt, hit_cnt
    );

    modport master (
        output start, mode_lfsr, seed, max_evals, max_hits, abort, sat, hit_ready,
        input  cand, hit_data, hit_valid, busy, done, eval_cnt, hit_cnt
    );
endinterface

// File: rtl/cand_hit_fifo.sv
// Synchronous FIFO buffering satisfying candidates; DEPTH must be a power of two.
// clr empties the buffer in one cycle and takes priority over push/pop.
module cand_hit_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/cand_sweep_gen.sv
// Candidate sweep generator: drives a linear or LFSR operand sweep into a
// combinational checker and streams satisfying candidates out over valid/ready.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_RUN   | one candidate evaluated per cycle unless the hit FIFO is full
//   ST_DRAIN | sweep stopped, waiting for the hit FIFO to empty
//   ST_DONE  | run finished, counters held, start accepted again
module cand_sweep_gen
    import cand_sweep_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    cand_sweep_if.slave bus
);
    // Budget down-counter must be able to hold 2^W for the full-space sweep.
    localparam int                LEFT_W     = (CNT_W > W) ? CNT_W : W + 1;
    localparam logic [LEFT_W-1:0] FULL_SPACE = LEFT_W'(1) << W;
    localparam logic [63:0]       TAPS_ALL   = lfsr_taps(W);
    localparam logic [W-1:0]      TAPS       = TAPS_ALL[W-1:0];

    state_t             state_q, state_d;
    logic [W-1:0]       cand_q, cand_d, cand_next;
    logic [CNT_W-1:0]   eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   max_hits_q, max_hits_d;
    logic [LEFT_W-1:0]  evals_left_q, evals_left_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;

    always_comb begin
        if (mode_q) cand_next = {1'b0, cand_q[W-1:1]} ^ (cand_q[0] ? TAPS : '0);
        else        cand_next = cand_q + W'(1);
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        eval_cnt_d   = eval_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        max_hits_d   = max_hits_q;
        evals_left_d = evals_left_q;
        mode_d       = mode_q;
        done_d       = 1'b0;
        fifo_clr     = 1'b0;
        fifo_push    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_RUN;
                    mode_d       = bus.mode_lfsr;
                    cand_d       = (bus.mode_lfsr && bus.seed == '0) ? W'(1) : bus.seed;
                    eval_cnt_d   = '0;
                    hit_cnt_d    = '0;
                    max_hits_d   = bus.max_hits;
                    evals_left_d = (bus.max_evals == '0) ? FULL_SPACE : LEFT_W'(bus.max_evals);
                    fifo_clr     = 1'b1;
                end
            end
            ST_RUN: begin
                // Full FIFO freezes the sweep so no result is sampled without a slot for it.
                if (!fifo_full) begin
                    eval_cnt_d   = (&eval_cnt_q) ? eval_cnt_q : eval_cnt_q + CNT_W'(1);
                    evals_left_d = evals_left_q - LEFT_W'(1);
                    cand_d       = cand_next;
                    if (bus.sat) begin
                        fifo_push = 1'b1;
                        hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
                    end
                end
                if (bus.abort ||
                    (!fifo_full && (evals_left_q == LEFT_W'(1) ||
                     (bus.sat && max_hits_q != '0 && hit_cnt_d == max_hits_q))))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            eval_cnt_q   <= '0;
            hit_cnt_q    <= '0;
            max_hits_q   <= '0;
            evals_left_q <= '0;
            mode_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            eval_cnt_q   <= eval_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            max_hits_q   <= max_hits_d;
            evals_left_q <= evals_left_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
        end
    end

    assign fifo_pop = !fifo_empty && bus.hit_ready;

    cand_hit_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data (cand_q),
        .pop       (fifo_pop),
        .rd_data   (bus.hit_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.cand      = cand_q;
    assign bus.hit_valid = !fifo_empty;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done      = done_q;
    assign bus.eval_cnt  = eval_cnt_q;
    assign bus.hit_cnt   = hit_cnt_q;
endmodule

// File: tb/tb_cand_sweep_gen.sv
// Directed bench for cand_sweep_gen: table of complete sweeps plus hand-written
// sequences for back-pressure stall, LFSR start/abort and mid-run reset.
module tb_cand_sweep_gen;
    logic clk = 1'b0;
    logic rst;
    logic chk_even;

    cand_sweep_if sif ();

    cand_sweep_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    // Checker model: always satisfied, or satisfied only for even candidates.
    always_comb sif.sat = chk_even ? ~sif.cand[0] : 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [20:0] got[$];
    int          n_done;

    task automatic do_start(input logic ml, input logic [20:0] sd,
                            input logic [31:0] me, input logic [31:0] mh);
        @(negedge clk);
        sif.start     = 1'b1;
        sif.mode_lfsr = ml;
        sif.seed      = sd;
        sif.max_evals = me;
        sif.max_hits  = mh;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    // Records accepted hits and done pulses; runs a few cycles past done to catch a second pulse.
    task automatic collect(input int budget);
        int tail;
        tail = -1;
        got.delete();
        n_done = 0;
        for (int c = 0; c < budget && tail != 0; c++) begin
            if (sif.hit_valid && sif.hit_ready) got.push_back(sif.hit_data);
            if (sif.done) begin
                n_done++;
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic        ml;
        logic        chk;
        logic [20:0] seed;
        logic [31:0] me;
        logic [31:0] mh;
        logic [3:0]  nh;
        logic [31:0] eval;
        logic [20:0] cend;
    } vec_t;

    localparam int NV = 5;
    vec_t        vecs     [NV];
    logic [20:0] exp_hits [NV][8];

    initial begin
        vecs[0] = '{ml:1'b0, chk:1'b0, seed:21'h0,      me:32'd5, mh:32'd0, nh:4'd5, eval:32'd5, cend:21'h5};
        exp_hits[0] = '{21'h0, 21'h1, 21'h2, 21'h3, 21'h4, 21'h0, 21'h0, 21'h0};
        vecs[1] = '{ml:1'b0, chk:1'b1, seed:21'h1FFFFE, me:32'd4, mh:32'd0, nh:4'd2, eval:32'd4, cend:21'h2};
        exp_hits[1] = '{21'h1FFFFE, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};
        vecs[2] = '{ml:1'b0, chk:1'b0, seed:21'h10,     me:32'd0, mh:32'd3, nh:4'd3, eval:32'd3, cend:21'h13};
        exp_hits[2] = '{21'h10, 21'h11, 21'h12, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};
        vecs[3] = '{ml:1'b1, chk:1'b0, seed:21'h5,      me:32'd3, mh:32'd0, nh:4'd3, eval:32'd3, cend:21'h110000};
        exp_hits[3] = '{21'h5, 21'h140002, 21'hA0001, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};
        vecs[4] = '{ml:1'b0, chk:1'b0, seed:21'h1FFFFF, me:32'd1, mh:32'd0, nh:4'd1, eval:32'd1, cend:21'h0};
        exp_hits[4] = '{21'h1FFFFF, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};

        rst = 1'b1;
        chk_even = 1'b0;
        sif.start = 1'b0; sif.mode_lfsr = 1'b0; sif.seed = '0;
        sif.max_evals = '0; sif.max_hits = '0; sif.abort = 1'b0; sif.hit_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cand", 32'(sif.cand), 32'h0);
        check("rst hit_valid", 32'(sif.hit_valid), 32'h0);
        check("rst busy", 32'(sif.busy), 32'h0);
        check("rst done", 32'(sif.done), 32'h0);
        check("rst eval_cnt", sif.eval_cnt, 32'h0);
        check("rst hit_cnt", sif.hit_cnt, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            chk_even = vecs[i].chk;
            sif.hit_ready = 1'b1;
            do_start(vecs[i].ml, vecs[i].seed, vecs[i].me, vecs[i].mh);
            collect(200);
            check($sformatf("v%0d nhits", i), 32'(got.size()), 32'(vecs[i].nh));
            for (int k = 0; k < int'(vecs[i].nh) && k < got.size(); k++)
                check($sformatf("v%0d hit%0d", i, k), 32'(got[k]), 32'(exp_hits[i][k]));
            check($sformatf("v%0d eval_cnt", i), sif.eval_cnt, vecs[i].eval);
            check($sformatf("v%0d hit_cnt", i), sif.hit_cnt, 32'(vecs[i].nh));
            check($sformatf("v%0d cand_end", i), 32'(sif.cand), 32'(vecs[i].cend));
            check($sformatf("v%0d done_pulses", i), 32'(n_done), 32'd1);
            check($sformatf("v%0d busy_end", i), 32'(sif.busy), 32'h0);
        end

        // Back-pressure: FIFO fills at 8 hits and the sweep freezes until drained.
        chk_even = 1'b0;
        sif.hit_ready = 1'b0;
        do_start(1'b0, 21'h100, 32'd20, 32'd0);
        repeat (15) @(negedge clk);
        check("stall eval_cnt", sif.eval_cnt, 32'd8);
        check("stall hit_cnt", sif.hit_cnt, 32'd8);
        check("stall cand", 32'(sif.cand), 32'h108);
        check("stall hit_valid", 32'(sif.hit_valid), 32'h1);
        check("stall hit_data", 32'(sif.hit_data), 32'h100);
        check("stall busy", 32'(sif.busy), 32'h1);
        @(negedge clk);
        check("stall hit_data held", 32'(sif.hit_data), 32'h100);
        sif.hit_ready = 1'b1;
        collect(300);
        check("stall nhits", 32'(got.size()), 32'd20);
        for (int k = 0; k < 20 && k < got.size(); k++)
            check($sformatf("stall hit%0d", k), 32'(got[k]), 32'h100 + 32'(k));
        check("stall eval_end", sif.eval_cnt, 32'd20);
        check("stall hit_end", sif.hit_cnt, 32'd20);
        check("stall done_pulses", 32'(n_done), 32'd1);

        // LFSR with zero seed, ignored restart, abort in the third RUN cycle.
        sif.hit_ready = 1'b0;
        do_start(1'b1, 21'h0, 32'd0, 32'd0);
        check("lfsr first cand", 32'(sif.cand), 32'h1);
        check("lfsr eval0", sif.eval_cnt, 32'd0);
        @(negedge clk);
        check("lfsr cand1", 32'(sif.cand), 32'h140000);
        check("lfsr busy", 32'(sif.busy), 32'h1);
        sif.start = 1'b1; sif.seed = 21'h55; sif.mode_lfsr = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        check("restart ignored cand", 32'(sif.cand), 32'hA0000);
        check("restart ignored eval", sif.eval_cnt, 32'd2);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("abort eval", sif.eval_cnt, 32'd3);
        check("abort hit", sif.hit_cnt, 32'd3);
        check("abort draining busy", 32'(sif.busy), 32'h1);
        check("abort cand held", 32'(sif.cand), 32'h50000);
        sif.hit_ready = 1'b1;
        collect(100);
        check("abort nhits", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("abort hit0", 32'(got[0]), 32'h1);
            check("abort hit1", 32'(got[1]), 32'h140000);
            check("abort hit2", 32'(got[2]), 32'hA0000);
        end
        check("abort eval_end", sif.eval_cnt, 32'd3);
        check("abort done_pulses", 32'(n_done), 32'd1);

        // Reset in the middle of a run with two hits buffered.
        sif.hit_ready = 1'b0;
        do_start(1'b0, 21'h40, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("pre-rst hit_cnt", sif.hit_cnt, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-rst hit_valid", 32'(sif.hit_valid), 32'h0);
        check("mid-rst eval_cnt", sif.eval_cnt, 32'd0);
        check("mid-rst hit_cnt", sif.hit_cnt, 32'd0);
        check("mid-rst busy", 32'(sif.busy), 32'h0);
        check("mid-rst cand", 32'(sif.cand), 32'h0);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        @(negedge clk);
        check("idle abort busy", 32'(sif.busy), 32'h0);
        check("idle abort cand", 32'(sif.cand), 32'h0);

        sif.hit_ready = 1'b1;
        do_start(1'b0, 21'h7, 32'd2, 32'd0);
        collect(100);
        check("post-rst nhits", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("post-rst hit0", 32'(got[0]), 32'h7);
            check("post-rst hit1", 32'(got[1]), 32'h8);
        end
        check("post-rst done_pulses", 32'(n_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
